// File: rtl/delay_line_sequencer.sv
// Sequencer for a shift_register_parallel delay line: decimated enable strobe,
// glitch-free length changes through a one-cycle flush, and primed-sample flagging.
module delay_line_sequencer #(
  parameter int MAX_LENGTH = 32,
  parameter int DIV_WIDTH  = 16,
  localparam int ADDR_WIDTH = $clog2(MAX_LENGTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [DIV_WIDTH-1:0]  rate_div,
  input  logic [ADDR_WIDTH-1:0] cfg_length,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  sr_reset,
  output logic                  sr_enable,
  output logic [ADDR_WIDTH-1:0] sr_length,
  output logic                  out_valid,
  output logic                  filling,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_cnt, div_d;
  logic [ADDR_WIDTH:0]   fill_cnt, fill_d;
  logic [ADDR_WIDTH:0]   len_ext, fill_inc, fill_sat;
  logic [ADDR_WIDTH-1:0] len_clamped, sr_length_d;
  logic                  sr_reset_d, sr_enable_d, out_valid_d, cfg_ready_d, filling_d;
  logic                  accept;

  // Handshake: a length request transfers on any rising edge where cfg_valid and
  // cfg_ready are both high; cfg_ready is registered and drops only during FLUSH.
  assign accept      = cfg_valid & cfg_ready;
  assign len_clamped = (int'(cfg_length) > MAX_LENGTH) ? ADDR_WIDTH'(MAX_LENGTH) : cfg_length;
  assign len_ext     = {1'b0, sr_length};
  assign fill_inc    = fill_cnt + (ADDR_WIDTH+1)'(1);
  assign fill_sat    = (fill_inc > len_ext) ? len_ext : fill_inc;
  assign dbg_state   = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sr_reset  <= 1'b1;
      sr_enable <= 1'b0;
      sr_length <= ADDR_WIDTH'(1);
      out_valid <= 1'b0;
      cfg_ready <= 1'b1;
      filling   <= 1'b0;
      div_cnt   <= '0;
      fill_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      sr_reset  <= sr_reset_d;
      sr_enable <= sr_enable_d;
      sr_length <= sr_length_d;
      out_valid <= out_valid_d;
      cfg_ready <= cfg_ready_d;
      filling   <= filling_d;
      div_cnt   <= div_d;
      fill_cnt  <= fill_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_reset_d  = sr_reset;
    sr_enable_d = 1'b0;
    sr_length_d = sr_length;
    out_valid_d = 1'b0;
    cfg_ready_d = 1'b1;
    div_d       = div_cnt;
    fill_d      = fill_cnt;

    case (state_q)
      IDLE: begin
        sr_reset_d = 1'b1;
        if (accept) sr_length_d = len_clamped;
        if (run) begin
          state_d    = FILL;
          sr_reset_d = 1'b0;
          div_d      = '0;
          fill_d     = '0;
        end
      end

      FILL, RUN: begin
        if (!run) begin
          state_d    = IDLE;
          sr_reset_d = 1'b1;
          div_d      = '0;
          fill_d     = '0;
          if (accept) sr_length_d = len_clamped;
        end else if (accept) begin
          // Clear the line for one cycle so old and new delays never mix.
          state_d     = FLUSH;
          sr_reset_d  = 1'b1;
          sr_length_d = len_clamped;
          cfg_ready_d = 1'b0;
          div_d       = '0;
          fill_d      = '0;
        end else begin
          sr_reset_d = 1'b0;
          // >= lets a lowered rate_div take effect without running past it.
          if (div_cnt >= rate_div) begin
            div_d       = '0;
            sr_enable_d = 1'b1;
          end else begin
            div_d = div_cnt + DIV_WIDTH'(1);
          end
          if (sr_enable) begin
            fill_d      = fill_sat;
            out_valid_d = (fill_sat >= len_ext);
          end
          if (state_q == FILL && fill_d >= len_ext) state_d = RUN;
        end
      end

      FLUSH: begin
        div_d  = '0;
        fill_d = '0;
        if (!run) begin
          state_d    = IDLE;
          sr_reset_d = 1'b1;
        end else begin
          state_d    = FILL;
          sr_reset_d = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        sr_reset_d = 1'b1;
      end
    endcase

    filling_d = (state_d == FILL);
  end

endmodule

// File: doc/delay_line_sequencer.md
# delay_line_sequencer

Controller for one `shift_register_parallel` delay line.
- Generates its `enable` strobe at a programmable decimated rate.
- Owns its `reset` and `length` inputs, so length changes never mix data from two different delays.
- Flags output samples once the line is fully primed for the active length.
- Sits between the sample-rate logic and the delay line; downstream consumers qualify `data_out` with `out_valid`.

## Interface
- MAX_LENGTH, 32, must equal the delay line's MAX_LENGTH
- DIV_WIDTH, 16, width of the rate divider
- ADDR_WIDTH, $clog2(MAX_LENGTH), localparam, width of length values
- clock  in  1  single clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = sequence the line, 0 = stop and hold the line cleared
- rate_div  in  DIV_WIDTH  strobe period minus one (0 = every cycle)
- cfg_length  in  ADDR_WIDTH  requested delay length
- cfg_valid  in  1  length-change request
- cfg_ready  out  1  request accepted when cfg_valid & cfg_ready
- sr_reset  out  1  to delay line `reset` (synchronous, active-high there)
- sr_enable  out  1  to delay line `enable`
- sr_length  out  ADDR_WIDTH  to delay line `length`
- out_valid  out  1  delay line `data_out` this cycle is a fully primed sample
- filling  out  1  1 in FILL state

## Operation
- States: IDLE, FILL, RUN, FLUSH. All outputs are registered.
- Reset values: state IDLE, sr_reset=1, sr_enable=0, sr_length=1, out_valid=0, cfg_ready=1, filling=0, div_cnt=0, fill_cnt=0.
- Length clamp: an accepted cfg_length is clamped to min(cfg_length, MAX_LENGTH) before it is loaded.
- Length 0 is legal. The line then outputs 0, and every strobe counts as primed.

State behaviour:
- IDLE:
  - sr_reset=1, sr_enable=0, out_valid=0.
  - An accepted cfg loads sr_length directly; the state stays IDLE.
  - run=1 → FILL, with div_cnt=0 and fill_cnt=0.
- FILL and RUN, divider:
  - Each cycle: if div_cnt >= rate_div, then div_cnt←0 and sr_enable←1 next cycle.
  - Otherwise div_cnt←div_cnt+1 and sr_enable←0.
  - The `>=` comparison makes a lowered rate_div take effect without overrun.
- FILL and RUN, fill count:
  - fill_cnt, ADDR_WIDTH+1 bits, increments on each sr_enable and saturates at sr_length.
  - out_valid←1 on the cycle after an sr_enable cycle whose post-increment fill_cnt >= sr_length. Otherwise out_valid←0.
  - FILL→RUN when fill_cnt reaches sr_length.
- FLUSH (entered on an accepted cfg in FILL/RUN):
  - For one cycle: sr_reset=1, sr_enable=0, out_valid=0, cfg_ready=0, sr_length=new value.
  - Then → FILL with div_cnt=0 and fill_cnt=0.
  - Any sr_enable that would have been issued at the acceptance cycle is suppressed.
- run=0 in FILL/RUN/FLUSH → IDLE next cycle. div_cnt and fill_cnt are cleared, and sr_reset rises.
- cfg_ready = 1 in IDLE/FILL/RUN, 0 in FLUSH.
- Simultaneous run falling and an accepted cfg: the length is loaded and the next state is IDLE (no FLUSH).
- reset_n asserted mid-operation: all registers return to their reset values immediately. sr_reset=1 keeps the line cleared.

## Timing
- run sampled 1 at cycle t in IDLE:
  - FILL at t+1.
  - sr_reset falls at t+1.
  - First sr_enable at t+2+rate_div, then every rate_div+1 cycles.
- out_valid:
  - Asserts one cycle after the sr_length-th sr_enable following FILL entry; for sr_length=0, one cycle after the first sr_enable.
  - Thereafter one cycle after every sr_enable.
- cfg accepted at t in FILL/RUN:
  - FLUSH at t+1, with sr_reset and the new sr_length.
  - FILL at t+2.
  - First new sr_enable at t+3+rate_div.
- Length-change latency to the first valid sample: 3 + rate_div + (L−1)(rate_div+1) + 1 cycles after acceptance, where L = new length ≥ 1.

## Test plan
- Reset/idle: hold reset_n=0, then release with run=0 → sr_reset=1, sr_enable=0, out_valid=0, cfg_ready=1, sr_length=1 for 20 cycles.
- Basic fill: rate_div=0, length=4, run↑ at t → sr_enable high continuously from t+2; out_valid first high at t+6; filling falls when fill_cnt=4.
- Decimation: rate_div=3, length=2 → sr_enable one cycle in 4, first at t+5; out_valid at t+10, t+14, …; with a reference delay model, data_out equals data_in from 2 strobes earlier whenever out_valid=1.
- Length change: in RUN, cfg_length=7 accepted at t → sr_reset=1 and sr_length=7 at t+1 only, cfg_ready=0 at t+1, no out_valid until 7 new strobes complete.
- Clamp and zero: MAX_LENGTH=20, cfg_length=31 → sr_length=20; cfg_length=0 → out_valid one cycle after the first strobe.
- Stop/abort: run↓ during FILL at fill_cnt=2, with a simultaneous cfg_length=5 → IDLE next cycle, sr_reset=1, sr_length=5; reset_n pulsed mid-RUN → outputs at reset values in the same cycle.
